// File: rtl/common_pkg.sv
// Shared pipeline types: EX-stage control bundle, controller state encoding
// and small helpers used by the hazard and stall logic.
package common_pkg;

  typedef struct packed {
    logic [4:0] write_back_id;
    logic       mem_read;
    logic       reg_write;
  } control_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MULDIV   = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [7:0] CNT8_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID cannot be covered by forwarding.
module load_use_detect
  import common_pkg::*;
(
  input  logic [4:0] rs_1,
  input  logic [4:0] rs_2,
  input  logic       rs_1_used,
  input  logic       rs_2_used,
  input  control_t   control_ex,
  output logic       hazard
);

  logic is_load;
  logic hit_1;
  logic hit_2;

  always_comb begin
    is_load = control_ex.mem_read && control_ex.reg_write &&
              (control_ex.write_back_id != REG_ZERO);
    hit_1   = rs_1_used && (control_ex.write_back_id == rs_1);
    hit_2   = rs_2_used && (control_ex.write_back_id == rs_2);
    hazard  = is_load && (hit_1 || hit_2);
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional performance
// counters (stall_cycles, flush_count) are built only with PIPE_PERF_EN.
module pipeline_controller
  import common_pkg::*;
#(
  parameter int MULDIV_CYCLES = 33,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_1,
  input  logic [4:0]  rs_2,
  input  logic        rs_1_used,
  input  logic        rs_2_used,
  input  control_t    control_ex,
  input  logic        muldiv_ex,
  input  logic        branch_taken_ex,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        bubble_wb,
  output logic        flush_id,
  output logic        muldiv_busy,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [7:0] MD_LAST   = 8'(MULDIV_CYCLES - 1);
  localparam logic [7:0] MEM_LIMIT = 8'(MEM_TIMEOUT);

  pipe_state_t state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [7:0]  mem_cnt_q, mem_cnt_d;
  logic        mem_timeout_err_q, mem_timeout_err_d;
  logic        hazard;

  load_use_detect u_load_use (
    .rs_1       (rs_1),
    .rs_2       (rs_2),
    .rs_1_used  (rs_1_used),
    .rs_2_used  (rs_2_used),
    .control_ex (control_ex),
    .hazard     (hazard)
  );

  always_comb begin
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    stall_ex          = 1'b0;
    stall_mem         = 1'b0;
    bubble_ex         = 1'b0;
    bubble_mem        = 1'b0;
    bubble_wb         = 1'b0;
    flush_id          = 1'b0;
    muldiv_busy       = 1'b0;
    state_d           = state_q;
    md_cnt_d          = md_cnt_q;
    mem_cnt_d         = mem_cnt_q;
    mem_timeout_err_d = mem_timeout_err_q;

    // Reset masks every control output; the flops are cleared in always_ff.
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
            state_d   = MEM_WAIT;
            mem_cnt_d = 8'd1;
          end else if (muldiv_ex) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            stall_ex    = 1'b1;
            bubble_mem  = 1'b1;
            muldiv_busy = 1'b1;
            state_d     = MULDIV;
            md_cnt_d    = 8'd1;
          end else if (branch_taken_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end

        MULDIV: begin
          muldiv_busy = 1'b1;
          if (md_cnt_q == MD_LAST) begin
            // Final cycle: the result advances, so a taken branch resolved
            // by this instruction is honoured as it would be in RUN.
            state_d  = RUN;
            md_cnt_d = 8'd0;
            if (branch_taken_ex) begin
              flush_id  = 1'b1;
              bubble_ex = 1'b1;
            end
          end else begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
            md_cnt_d   = md_cnt_q + 8'd1;
          end
        end

        MEM_WAIT: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          bubble_wb = 1'b1;
          if (mem_ready) begin
            state_d   = RUN;
            mem_cnt_d = 8'd0;
          end else begin
            mem_cnt_d = sat_inc8(mem_cnt_q);
          end
        end

        default: begin
          state_d   = RUN;
          md_cnt_d  = 8'd0;
          mem_cnt_d = 8'd0;
        end
      endcase

      if ((state_d == MEM_WAIT) && (mem_cnt_d >= MEM_LIMIT)) begin
        mem_timeout_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= RUN;
      md_cnt_q          <= 8'd0;
      mem_cnt_q         <= 8'd0;
      mem_timeout_err_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      md_cnt_q          <= md_cnt_d;
      mem_cnt_q         <= mem_cnt_d;
      mem_timeout_err_q <= mem_timeout_err_d;
    end
  end

  assign mem_timeout_err = mem_timeout_err_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_if};
    flush_count_d  = flush_count_q + {31'd0, flush_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards that operand forwarding cannot cover.
- Sequences multi-cycle mul/div operations in EX with a fixed-latency counter.
- Freezes the pipeline while data memory is not ready, with a timeout watchdog.
- Generates branch/jump flushes.
- Drives per-stage stall enables and bubble insertion for the pipeline registers.

Parameters:
- MULDIV_CYCLES, 33: number of EX cycles a mul/div occupies, including the issue cycle; legal range 2..255.
- MEM_TIMEOUT, 255: consecutive not-ready cycles in MEM_WAIT before mem_timeout_err is set; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_1  in  5  ID-stage source register 1
- rs_2  in  5  ID-stage source register 2
- rs_1_used  in  1  ID instruction reads rs_1
- rs_2_used  in  1  ID instruction reads rs_2
- control_ex  in  control_t  EX-stage control; uses write_back_id, mem_read, reg_write
- muldiv_ex  in  1  EX instruction is mul/div
- branch_taken_ex  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage performs a load or store
- mem_ready  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register
- stall_mem  out  1  hold EX/MEM register
- bubble_ex  out  1  load NOP into ID/EX
- bubble_mem  out  1  load NOP into EX/MEM
- bubble_wb  out  1  load NOP into MEM/WB
- flush_id  out  1  clear IF/ID
- muldiv_busy  out  1  mul/div sequencing in progress
- mem_timeout_err  out  1  sticky memory-timeout flag
- stall_cycles  out  32  performance counter (optional)
- flush_count  out  32  performance counter (optional)

Behaviour:
State machine states: RUN, MULDIV, MEM_WAIT. Outputs are combinational from the current state and the inputs; state, counters and the error flag are registered.

Reset:
- State goes to RUN; md_cnt=0, mem_cnt=0, mem_timeout_err=0, perf counters=0.
- While rst=1, all stall, bubble and flush outputs are 0 regardless of inputs.
- A reset asserted mid-MULDIV or mid-MEM_WAIT aborts the sequence; RUN is entered on the next edge.

Priority in RUN (first match wins):
1. mem_req & !mem_ready:
   - stall_if, stall_id, stall_ex and stall_mem all =1; bubble_wb=1.
   - Next state MEM_WAIT, mem_cnt=1.
2. muldiv_ex:
   - stall_if, stall_id and stall_ex =1; bubble_mem=1.
   - Next state MULDIV, md_cnt=1.
3. branch_taken_ex:
   - flush_id=1, bubble_ex=1; stay in RUN.
   - Overrides a load-use hazard in the same cycle, since the ID instruction is on the wrong path.
4. Load-use hazard:
   - Condition: control_ex.mem_read & control_ex.reg_write & write_back_id!=0 & ((write_back_id==rs_1 & rs_1_used) | (write_back_id==rs_2 & rs_2_used)).
   - stall_if=1, stall_id=1, bubble_ex=1 for exactly one cycle; stay in RUN.
5. Otherwise: all outputs 0.

MULDIV:
- Same stall/bubble outputs as the RUN muldiv issue cycle; md_cnt increments each cycle.
- When md_cnt==MULDIV_CYCLES-1, stalls drop on that cycle, the result advances, and the next state is RUN.
- If branch_taken_ex is asserted on the final cycle, it is handled as in RUN on that cycle.

MEM_WAIT:
- Full freeze: stall_if, stall_id, stall_ex and stall_mem =1; bubble_wb=1.
- mem_ready=1: that cycle still counts as a MEM_WAIT cycle with the full freeze asserted; next state RUN.
- mem_ready=0: mem_cnt increments, saturating at 255.
- When mem_cnt reaches MEM_TIMEOUT, mem_timeout_err latches to 1 until reset; the controller stays in MEM_WAIT.

muldiv_busy: 1 while in MULDIV, and in RUN during the issue cycle.

Optional Feature:
Macro PIPE_PERF_EN.
- Defined:
  - stall_cycles increments every cycle in which stall_if=1.
  - flush_count increments every cycle in which flush_id=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by rst.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Shared package common_pkg:
  - Existing control_t.
  - New pipe_state_t enum {RUN, MULDIV, MEM_WAIT}.
  - Localparam REG_ZERO=5'd0.
- Sub-module load_use_detect: purely combinational; inputs rs_1, rs_2, rs_1_used, rs_2_used, control_ex; output hazard.

Test Plan:
- Load x5 in EX, ID reads rs_1=5 (used) -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then all 0.
- Same as previous but write_back_id=0, or rs_1_used=0 -> no stall.
- muldiv_ex=1 with MULDIV_CYCLES=4 -> stalls high for 3 cycles (issue plus 2 in MULDIV), low on cycle 4; muldiv_busy high for cycles 1-4.
- mem_req=1, mem_ready low for 3 cycles then high -> full freeze for 4 cycles, then RUN; mem_timeout_err=0.
- MEM_TIMEOUT=5, mem_ready held 0 -> mem_timeout_err=1 at the 5th stall cycle, stays 1; rst mid-wait -> RUN, flag cleared, outputs 0 during reset.
- branch_taken_ex together with a load-use hazard -> flush_id=1, bubble_ex=1, stall_if=0; with PIPE_PERF_EN, flush_count=1 and stall_cycles unchanged.
